// File: rtl/cb_cfg_pkg.sv
// Shared types and elaboration-time helpers for the double-buffered connection-block
// configuration path.
package cb_cfg_pkg;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      LOADING = 2'd1,
      FULL    = 2'd2,
      OVER    = 2'd3
   } cb_cfg_state_e;

   localparam int CB_CHAN_W_DEF     = 9;
   localparam int CB_NUM_IPIN_DEF   = 11;
   localparam int CB_MUX_SIZE_DEF   = 6;
   localparam int CB_TRACK_STEP_DEF = 4;

   // A 1:1 "mux" still needs one select bit so the config word is never zero-width.
   function automatic int cb_sel_w(input int mux_size);
      return (mux_size > 1) ? $clog2(mux_size) : 1;
   endfunction

   function automatic int cb_cfg_bits(input int num_ipin, input int mux_size);
      return num_ipin * cb_sel_w(mux_size);
   endfunction

   // Counter must reach CFG_BITS+1 so an over-long load is distinguishable from a full one.
   function automatic int cb_cnt_w(input int cfg_bits);
      return $clog2(cfg_bits + 2);
   endfunction

   function automatic int cb_track_idx(input int i, input int m, input int step, input int w);
      return (i + m * step) % w;
   endfunction

endpackage

// File: rtl/cb_ipin_mux.sv
// One grid-pin routing mux: selects in_i[sel_i], forced low when disabled or when the
// select code has no corresponding input.
module cb_ipin_mux #(
   parameter int MUX_SIZE = 6,
   parameter int SEL_W    = 3
) (
   input  logic [MUX_SIZE-1:0] in_i,
   input  logic [SEL_W-1:0]    sel_i,
   input  logic                en_i,
   output logic                out_o
);

   always_comb begin
      out_o = 1'b0;
      for (int k = 0; k < MUX_SIZE; k++) begin
         if (en_i && (sel_i == SEL_W'(k))) begin
            out_o = in_i[k];
         end
      end
   end

endmodule

// File: rtl/cby_param_dbuf.sv
// Parametrised Y-direction connection block: channel pass-through, NUM_IPIN routing muxes,
// and a shadow/active configuration pair so reprogramming never disturbs live routing.
module cby_param_dbuf
   import cb_cfg_pkg::*;
#(
   parameter int CHAN_W     = CB_CHAN_W_DEF,
   parameter int NUM_IPIN   = CB_NUM_IPIN_DEF,
   parameter int MUX_SIZE   = CB_MUX_SIZE_DEF,
   parameter int TRACK_STEP = CB_TRACK_STEP_DEF
) (
   input  logic                prog_clk,
   input  logic                prog_reset_n,
   input  logic                ccff_en,
   input  logic                ccff_head,
   input  logic                ccff_commit,
   output logic                ccff_tail,
   input  logic [CHAN_W-1:0]   chany_bottom_in,
   input  logic [CHAN_W-1:0]   chany_top_in,
   output logic [CHAN_W-1:0]   chany_top_out,
   output logic [CHAN_W-1:0]   chany_bottom_out,
   output logic [NUM_IPIN-1:0] ipin_out,
   output logic                cfg_valid,
   output logic                cfg_full,
   output logic                cfg_err
);

   localparam int SEL_W    = cb_sel_w(MUX_SIZE);
   localparam int CFG_BITS = cb_cfg_bits(NUM_IPIN, MUX_SIZE);
   localparam int CNT_W    = cb_cnt_w(CFG_BITS);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_BITS + 1);

   logic [CFG_BITS-1:0] shadow_q, shadow_d;
   logic [CFG_BITS-1:0] active_q, active_d;
   logic [CNT_W-1:0]    count_q, count_d;
   cb_cfg_state_e       state_q, state_d;
   logic                valid_q, valid_d;
   logic                err_q, err_d;
   logic                commit_ok;

   // A commit that coincides with a shift is refused: the shadow would be mid-update.
   always_comb begin
      commit_ok = ccff_commit && !ccff_en && (state_q == FULL);

      shadow_d = shadow_q;
      if (ccff_en) begin
         shadow_d = {shadow_q[CFG_BITS-2:0], ccff_head};
      end

      active_d = commit_ok ? shadow_q : active_q;
      valid_d  = valid_q || commit_ok;
      err_d    = ccff_commit && !commit_ok;

      count_d = count_q;
      if (commit_ok) begin
         count_d = '0;
      end else if (ccff_en && (count_q != CNT_SAT)) begin
         count_d = count_q + CNT_W'(1);
      end

      if (count_d == '0) begin
         state_d = EMPTY;
      end else if (count_d < CNT_FULL) begin
         state_d = LOADING;
      end else if (count_d == CNT_FULL) begin
         state_d = FULL;
      end else begin
         state_d = OVER;
      end
   end

   always_ff @(posedge prog_clk or negedge prog_reset_n) begin
      if (!prog_reset_n) begin
         shadow_q <= '0;
         active_q <= '0;
         count_q  <= '0;
         state_q  <= EMPTY;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         count_q  <= count_d;
         state_q  <= state_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
      end
   end

   assign ccff_tail        = shadow_q[CFG_BITS-1];
   assign cfg_valid        = valid_q;
   assign cfg_full         = (state_q == FULL);
   assign cfg_err          = err_q;
   assign chany_top_out    = chany_bottom_in;
   assign chany_bottom_out = chany_top_in;

   // Even mux inputs come from below, odd from above, sharing one track per pair.
   generate
      for (genvar gi = 0; gi < NUM_IPIN; gi++) begin : g_ipin
         logic [MUX_SIZE-1:0] mux_in;

         for (genvar gm = 0; gm < MUX_SIZE / 2; gm++) begin : g_pair
            localparam int TRK = cb_track_idx(gi, gm, TRACK_STEP, CHAN_W);
            assign mux_in[2*gm]   = chany_bottom_in[TRK];
            assign mux_in[2*gm+1] = chany_top_in[TRK];
         end

         cb_ipin_mux #(
            .MUX_SIZE (MUX_SIZE),
            .SEL_W    (SEL_W)
         ) u_mux (
            .in_i  (mux_in),
            .sel_i (active_q[gi*SEL_W +: SEL_W]),
            .en_i  (valid_q),
            .out_o (ipin_out[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_cby_param_dbuf.sv
// Directed self-checking bench for cby_param_dbuf at default parameters.
module tb_cby_param_dbuf;

   logic        prog_clk;
   logic        prog_reset_n;
   logic        ccff_en;
   logic        ccff_head;
   logic        ccff_commit;
   logic        ccff_tail;
   logic [8:0]  chany_bottom_in;
   logic [8:0]  chany_top_in;
   logic [8:0]  chany_top_out;
   logic [8:0]  chany_bottom_out;
   logic [10:0] ipin_out;
   logic        cfg_valid;
   logic        cfg_full;
   logic        cfg_err;

   int n_checks = 0;
   int n_errors = 0;

   cby_param_dbuf dut (
      .prog_clk         (prog_clk),
      .prog_reset_n     (prog_reset_n),
      .ccff_en          (ccff_en),
      .ccff_head        (ccff_head),
      .ccff_commit      (ccff_commit),
      .ccff_tail        (ccff_tail),
      .chany_bottom_in  (chany_bottom_in),
      .chany_top_in     (chany_top_in),
      .chany_top_out    (chany_top_out),
      .chany_bottom_out (chany_bottom_out),
      .ipin_out         (ipin_out),
      .cfg_valid        (cfg_valid),
      .cfg_full         (cfg_full),
      .cfg_err          (cfg_err)
   );

   initial prog_clk = 1'b0;
   always #5 prog_clk = ~prog_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge prog_clk);
      #1;
   endtask

   task automatic do_reset();
      prog_reset_n = 1'b0;
      tick();
      prog_reset_n = 1'b1;
      tick();
   endtask

   // Shifts w[n-1] first, so a full 33-bit word lands with w[i] at shadow[i].
   task automatic shift_bits(input logic [39:0] w, input int n);
      for (int k = n - 1; k >= 0; k--) begin
         ccff_en   = 1'b1;
         ccff_head = w[k];
         tick();
      end
      ccff_en   = 1'b0;
      ccff_head = 1'b0;
   endtask

   task automatic commit();
      ccff_commit = 1'b1;
      tick();
      ccff_commit = 1'b0;
   endtask

   function automatic logic [32:0] fill_all(input logic [2:0] sel);
      logic [32:0] w;
      for (int i = 0; i < 11; i++) w[i*3 +: 3] = sel;
      return w;
   endfunction

   // Reference routing: pair m = sel/2 uses track (i + 4m) % 9, odd selects take the top channel.
   function automatic logic [10:0] exp_ipin(input logic [32:0] act, input logic v,
                                            input logic [8:0] b, input logic [8:0] t);
      logic [10:0] r;
      int sel;
      int trk;
      for (int i = 0; i < 11; i++) begin
         sel  = int'(act[i*3 +: 3]);
         r[i] = 1'b0;
         if (v && sel < 6) begin
            trk  = (i + 4 * (sel / 2)) % 9;
            r[i] = (sel % 2 == 1) ? t[trk] : b[trk];
         end
      end
      return r;
   endfunction

   logic [32:0] act;
   logic [8:0]  bv [4];
   logic [8:0]  tv [4];

   initial begin
      bv[0] = 9'h1A5; tv[0] = 9'h0C3;
      bv[1] = 9'h1FF; tv[1] = 9'h000;
      bv[2] = 9'h000; tv[2] = 9'h1FF;
      bv[3] = 9'h055; tv[3] = 9'h1AA;

      prog_reset_n    = 1'b0;
      ccff_en         = 1'b0;
      ccff_head       = 1'b0;
      ccff_commit     = 1'b0;
      chany_bottom_in = '0;
      chany_top_in    = '0;
      tick();
      tick();
      prog_reset_n = 1'b1;
      tick();

      // 1: reset state and pass-through
      chany_bottom_in = 9'h1A5;
      chany_top_in    = 9'h0C3;
      #1;
      check("rst_top_out", chany_top_out, 9'h1A5);
      check("rst_bottom_out", chany_bottom_out, 9'h0C3);
      check("rst_ipin", ipin_out, 11'h000);
      check("rst_valid", cfg_valid, 1'b0);
      check("rst_tail", ccff_tail, 1'b0);
      check("rst_err", cfg_err, 1'b0);
      check("rst_full", cfg_full, 1'b0);

      // 2: ipin0 sel=1, others sel=0
      act = '0;
      act[2:0] = 3'd1;
      shift_bits({7'd0, act}, 33);
      check("t2_full", cfg_full, 1'b1);
      check("t2_valid_pre", cfg_valid, 1'b0);
      commit();
      check("t2_valid", cfg_valid, 1'b1);
      check("t2_err", cfg_err, 1'b0);
      check("t2_full_after", cfg_full, 1'b0);
      chany_bottom_in = 9'h1A5;
      chany_top_in    = 9'h0C3;
      #1;
      check("t2_ipin_hand", ipin_out, 11'h3A5);
      for (int p = 0; p < 4; p++) begin
         chany_bottom_in = bv[p];
         chany_top_in    = tv[p];
         #1;
         check($sformatf("t2_ipin_p%0d", p), ipin_out, exp_ipin(act, 1'b1, bv[p], tv[p]));
      end

      // 3: short load rejected, routing unchanged
      shift_bits(40'hFF_FFFF_FFFF, 32);
      check("t3_full", cfg_full, 1'b0);
      commit();
      check("t3_err_pulse", cfg_err, 1'b1);
      tick();
      check("t3_err_clear", cfg_err, 1'b0);
      check("t3_valid", cfg_valid, 1'b1);
      chany_bottom_in = 9'h055;
      chany_top_in    = 9'h1AA;
      #1;
      check("t3_ipin", ipin_out, exp_ipin(act, 1'b1, 9'h055, 9'h1AA));

      // 4: a single 1 reaches the tail on shift 33 only
      do_reset();
      for (int k = 1; k <= 40; k++) begin
         ccff_en   = 1'b1;
         ccff_head = (k == 1);
         tick();
         check($sformatf("t4_tail_%0d", k), ccff_tail, (k == 33));
         if (k == 33 || k == 34) check($sformatf("t4_full_%0d", k), cfg_full, (k == 33));
      end
      ccff_en   = 1'b0;
      ccff_head = 1'b0;
      commit();
      check("t4_over_err", cfg_err, 1'b1);
      check("t4_valid", cfg_valid, 1'b0);

      // 5: out-of-range select gates the pin, sel=4 picks bottom[3]
      do_reset();
      act = '0;
      act[14:12] = 3'd7;
      shift_bits({7'd0, act}, 33);
      commit();
      check("t5_valid", cfg_valid, 1'b1);
      for (int p = 0; p < 4; p++) begin
         chany_bottom_in = bv[p];
         chany_top_in    = tv[p];
         #1;
         check($sformatf("t5_sel7_p%0d", p), ipin_out[4], 1'b0);
      end
      act[14:12] = 3'd4;
      shift_bits({7'd0, act}, 33);
      commit();
      check("t5_err", cfg_err, 1'b0);
      chany_bottom_in = 9'h008;
      chany_top_in    = 9'h000;
      #1;
      check("t5_sel4_one", ipin_out[4], 1'b1);
      chany_bottom_in = 9'h1F7;
      chany_top_in    = 9'h1FF;
      #1;
      check("t5_sel4_zero", ipin_out[4], 1'b0);
      check("t5_ipin_all", ipin_out, exp_ipin(act, 1'b1, 9'h1F7, 9'h1FF));

      // 6: commit together with shift in FULL is rejected and pushes count past full
      do_reset();
      shift_bits({7'd0, fill_all(3'd2)}, 33);
      check("t6_full", cfg_full, 1'b1);
      ccff_en     = 1'b1;
      ccff_head   = 1'b0;
      ccff_commit = 1'b1;
      tick();
      ccff_en     = 1'b0;
      ccff_commit = 1'b0;
      check("t6_err", cfg_err, 1'b1);
      check("t6_full_after", cfg_full, 1'b0);
      check("t6_valid", cfg_valid, 1'b0);
      commit();
      check("t6_over_err", cfg_err, 1'b1);
      check("t6_over_valid", cfg_valid, 1'b0);

      // Reset asserted mid-load clears outputs without waiting for a clock edge
      do_reset();
      act = fill_all(3'd3);
      shift_bits({7'd0, act}, 33);
      commit();
      chany_bottom_in = 9'h000;
      chany_top_in    = 9'h1FF;
      #1;
      check("t6_live_ipin", ipin_out, 11'h7FF);
      shift_bits(40'h00_0000_03FF, 10);
      check("t6_tail_pre", ccff_tail, 1'b1);
      #2;
      prog_reset_n = 1'b0;
      #1;
      check("t6_async_ipin", ipin_out, 11'h000);
      check("t6_async_valid", cfg_valid, 1'b0);
      check("t6_async_tail", ccff_tail, 1'b0);
      check("t6_async_full", cfg_full, 1'b0);
      tick();
      prog_reset_n = 1'b1;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
